// File: rtl/alu_mdu.sv
// EX-stage integer unit: RV32I ALU ops plus RV32M multiply/divide (shift-add multiplier, restoring divider).
// Latency: 1 cycle for base ops and divide early-outs, WIDTH+1 cycles for iterative MUL/DIV ops.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid & out_ready; flush kills any op.
module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SHW:0]     CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]     CNT_ONE  = (SHW+1)'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [SHW:0]       cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [1:0]         sub_q;
    logic               div_q;
    logic               neg_q;
    logic [WIDTH-1:0]   result_q;
    logic               z_q, n_q, v_q, c_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign z         = z_q;
    assign n         = n_q;
    assign v         = v_q;
    assign c         = c_q;

    // Base ALU: SUB is folded into the adder as a + ~b + 1 so carry/overflow share one path.
    logic             sub_op;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   add_full;
    logic             add_v;
    logic [WIDTH-1:0] base_res;
    logic             base_c, base_v;

    assign sub_op   = (op == 5'd1);
    assign b_add    = sub_op ? ~b : b;
    assign add_full = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_op};
    assign add_v    = (a[WIDTH-1] == b_add[WIDTH-1]) & (add_full[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        base_res = '0;
        base_c   = 1'b0;
        base_v   = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                base_res = add_full[WIDTH-1:0];
                base_c   = add_full[WIDTH];
                base_v   = add_v;
            end
            5'd2: base_res = a & b;
            5'd3: base_res = a | b;
            5'd4: base_res = a ^ b;
            5'd5: base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd6: base_res = a << b[SHW-1:0];
            5'd7: base_res = $signed(a) >>> b[SHW-1:0];
            5'd8: base_res = a >> b[SHW-1:0];
            5'd9: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: base_res = '0;
        endcase
    end

    // M-op decode: sub-op 00/01/10/11 = MUL/MULH/MULHSU/MULHU or DIV/DIVU/REM/REMU.
    logic             m_op, m_div;
    logic [1:0]       m_sub;
    logic             a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic             div_zero, div_ovf, early;
    logic [WIDTH-1:0] mag_a, mag_b, early_res;

    assign m_op     = op[4] & ~op[3];
    assign m_div    = op[2];
    assign m_sub    = op[1:0];
    assign a_sgn    = m_div ? ~m_sub[0] : (m_sub == 2'b01 || m_sub == 2'b10);
    assign b_sgn    = m_div ? ~m_sub[0] : (m_sub == 2'b01);
    assign a_neg    = a_sgn & a[WIDTH-1];
    assign b_neg    = b_sgn & b[WIDTH-1];
    assign mag_a    = a_neg ? -a : a;
    assign mag_b    = b_neg ? -b : b;
    // The remainder takes the dividend's sign; quotient and product take the XOR of both.
    assign res_neg  = (m_div & m_sub[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = m_div & (b == '0);
    assign div_ovf  = m_div & a_sgn & (a == MIN_NEG) & (b == '1);
    assign early    = div_zero | div_ovf;
    assign early_res = div_zero ? (m_sub[1] ? a : '1) : (m_sub[1] ? '0 : a);

    // One iteration: prod_q holds {acc, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step, mul_full;
    logic [WIDTH-1:0]   div_val, fin_res;

    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign div_sh   = prod_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_sh >= {1'b0, mcand_q});
    assign div_diff = div_sh - {1'b0, mcand_q};
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign step     = div_q ? {div_rem, prod_q[WIDTH-2:0], div_ge}
                            : {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_full = neg_q ? -step : step;
    assign div_val  = sub_q[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];

    always_comb begin
        fin_res = '0;
        if (div_q)
            fin_res = neg_q ? -div_val : div_val;
        else if (sub_q == 2'b00)
            fin_res = mul_full[WIDTH-1:0];
        else
            fin_res = mul_full[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            sub_q    <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (m_op && !early) begin
                            prod_q  <= {{WIDTH{1'b0}}, (m_div ? mag_a : mag_b)};
                            mcand_q <= m_div ? mag_b : mag_a;
                            sub_q   <= m_sub;
                            div_q   <= m_div;
                            neg_q   <= res_neg;
                            cnt_q   <= CNT_INIT;
                            state_q <= BUSY;
                        end else begin
                            result_q <= m_op ? early_res : base_res;
                            z_q      <= ((m_op ? early_res : base_res) == '0);
                            n_q      <= m_op ? early_res[WIDTH-1] : base_res[WIDTH-1];
                            v_q      <= ~m_op & base_v;
                            c_q      <= ~m_op & base_c;
                            state_q  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    prod_q <= step;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_q <= fin_res;
                        z_q      <= (fin_res == '0);
                        n_q      <= fin_res[WIDTH-1];
                        v_q      <= 1'b0;
                        c_q      <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, multi-cycle corner sequences, and random ops against an arithmetic model.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   op;
    logic [W-1:0] a, b, result;
    logic         z, n, v, c;

    int checks   = 0;
    int failures = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .z(z), .n(n), .v(v), .c(c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  f;   // {z, n, v, c}
        int          lat;
    } vec_t;

    vec_t        tbl[24];
    logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    logic [4:0]  ops[20]    = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd31};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the RV32 rules in plain 64-bit / int arithmetic.
    function automatic void ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output logic [3:0] f, output int lat);
        longint      sx, sy, p;
        logic [63:0] ux, uy, pu;
        int          ix, iy;
        logic        vv, cc;
        sx = $signed(x); sy = $signed(y);
        ux = {32'b0, x}; uy = {32'b0, y};
        ix = x; iy = y;
        r = '0; vv = 1'b0; cc = 1'b0; lat = 1;
        case (o)
            5'd0: begin p = sx + sy; r = p[31:0]; vv = (p != longint'($signed(r))); cc = ((ux + uy) > 64'hFFFF_FFFF); end
            5'd1: begin p = sx - sy; r = p[31:0]; vv = (p != longint'($signed(r))); cc = (x >= y); end
            5'd2: r = x & y;
            5'd3: r = x | y;
            5'd4: r = x ^ y;
            5'd5: r = (ix < iy) ? 32'd1 : 32'd0;
            5'd6: r = x << y[4:0];
            5'd7: r = ix >>> y[4:0];
            5'd8: r = x >> y[4:0];
            5'd9: r = (x < y) ? 32'd1 : 32'd0;
            5'd16: begin pu = ux * uy; r = pu[31:0]; lat = 33; end
            5'd17: begin p = sx * sy; r = p[63:32]; lat = 33; end
            5'd18: begin p = sx * longint'(uy); r = p[63:32]; lat = 33; end
            5'd19: begin pu = ux * uy; r = pu[63:32]; lat = 33; end
            5'd20: if (y == 0) r = '1;
                   else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                   else begin r = ix / iy; lat = 33; end
            5'd21: if (y == 0) r = '1; else begin r = x / y; lat = 33; end
            5'd22: if (y == 0) r = x;
                   else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
                   else begin r = ix % iy; lat = 33; end
            5'd23: if (y == 0) r = x; else begin r = x % y; lat = 33; end
            default: r = '0;
        endcase
        f = {(r == 0), r[31], vv, cc};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0, 1:    return $urandom();
            2:       return corners[$urandom_range(0, 5)];
            default: return $urandom_range(0, 20);
        endcase
    endfunction

    // Called just after a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic start_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL start_timeout in_ready=%0b required=1", in_ready);
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f, output int lat, output int viol);
        viol = 0;
        start_op(o, x, y);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) viol++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
        end
        if (in_ready) viol++;
        r = result;
        f = {z, n, v, c};
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat, elat, viol, hits;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_result", result, 0);
        check("reset_flags", {z, n, v, c}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0110, 1};
        tbl[1]  = '{5'd1,  32'h5,         32'h5,         32'h0,         4'b1001, 1};
        tbl[2]  = '{5'd7,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 1};
        tbl[3]  = '{5'd9,  32'h1,         32'hFFFF_FFFF, 32'h1,         4'b0000, 1};
        tbl[4]  = '{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         4'b1000, 33};
        tbl[5]  = '{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 33};
        tbl[6]  = '{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         4'b0000, 33};
        tbl[7]  = '{5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 4'b0100, 33};
        tbl[8]  = '{5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 4'b0100, 33};
        tbl[9]  = '{5'd21, 32'hA,         32'h0,         32'hFFFF_FFFF, 4'b0100, 1};
        tbl[10] = '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         4'b1000, 1};
        tbl[11] = '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0100, 1};
        tbl[12] = '{5'd12, 32'h5,         32'h6,         32'h0,         4'b1000, 1};
        tbl[13] = '{5'd5,  32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1};
        tbl[14] = '{5'd6,  32'h1,         32'h21,        32'h2,         4'b0000, 1};
        tbl[15] = '{5'd8,  32'h8000_0000, 32'h4,         32'h0800_0000, 4'b0000, 1};
        tbl[16] = '{5'd23, 32'hA,         32'h0,         32'hA,         4'b0000, 1};
        tbl[17] = '{5'd18, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 4'b0100, 33};
        tbl[18] = '{5'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0100, 1};
        tbl[19] = '{5'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011, 1};
        tbl[20] = '{5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1001, 1};
        tbl[21] = '{5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         4'b1000, 33};
        tbl[22] = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 1};
        tbl[23] = '{5'd3,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000, 1};

        for (int i = 0; i < 24; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, viol);
            check($sformatf("vec%0d_result", i), r, tbl[i].res);
            check($sformatf("vec%0d_flags", i), f, tbl[i].f);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_in_ready_while_busy", i), viol, 0);
        end

        // Reset while a multiply iterates.
        start_op(5'd16, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy_out_valid", out_valid, 0);
        check("rst_busy_in_ready", in_ready, 1);
        check("rst_busy_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(5'd0, 32'd1, 32'd2, r, f, lat, viol);
        check("post_rst_add", r, 3);
        check("post_rst_add_latency", lat, 1);

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        start_op(5'd0, 32'd3, 32'd4);
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            op = 5'd1; a = 32'd9; b = 32'd1; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d_result", i), result, 7);
            check($sformatf("bp%0d_flags", i), {z, n, v, c}, 4'b0000);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        check("bp_ignored_op_out_valid", out_valid, 0);

        // Flush in the middle of a divide.
        start_op(5'd21, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_in_ready", in_ready, 1);
        check("flush_div_out_valid", out_valid, 0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("flush_div_never_valid", hits, 0);

        // Flush with a simultaneous request in IDLE.
        op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", in_ready, 1);
        check("flush_idle_out_valid", out_valid, 0);
        @(negedge clk);
        check("flush_idle_out_valid_later", out_valid, 0);

        // Flush while a result waits in DONE, overriding out_ready.
        out_ready = 1'b0;
        start_op(5'd0, 32'd1, 32'd1);
        check("flush_done_pre_valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_out_valid", out_valid, 0);
        check("flush_done_in_ready", in_ready, 1);

        for (int i = 0; i < 300; i++) begin
            logic [4:0]  o;
            logic [31:0] x, y;
            o = ops[$urandom_range(0, 19)];
            x = pick();
            y = pick();
            ref_model(o, x, y, er, ef, elat);
            run_op(o, x, y, r, f, lat, viol);
            check($sformatf("rnd%0d_op%0d_%h_%h_result", i, o, x, y), r, er);
            check($sformatf("rnd%0d_op%0d_flags", i, o), f, ef);
            check($sformatf("rnd%0d_op%0d_latency", i, o), lat, elat);
            check($sformatf("rnd%0d_op%0d_in_ready_while_busy", i, o), viol, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
